// File: rtl/nmr_pkg.sv
// Shared constants and state encoding for the NMR acquisition capture path.
// One-hot FSM states and default sample/word widths.
package nmr_pkg;

  localparam int ADC_W_DEF  = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_WAIT  = 4'b0010,
    S_CAP   = 4'b0100,
    S_FLUSH = 4'b1000
  } state_t;

  // Lane index width, kept at least 1 bit when one sample fills a word.
  function automatic int idx_w(input int spw);
    return (spw > 1) ? $clog2(spw) : 1;
  endfunction

endpackage

// File: rtl/nmr_sample_packer.sv
// Packs ADC samples into FIFO words, issues full or flushed partial words.
// Words that meet a full FIFO are dropped and reported through DROP.
module nmr_sample_packer
  import nmr_pkg::*;
#(
  parameter int ADC_WIDTH        = ADC_W_DEF,
  parameter int SAMPLES_PER_WORD = 2,
  parameter int DATA_WIDTH       = DATA_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CLR,
  input  logic                  STROBE,
  input  logic [ADC_WIDTH-1:0]  SAMPLE,
  input  logic                  FLUSH,
  input  logic                  FIFO_FULL,
  output logic                  FIFO_WR,
  output logic [DATA_WIDTH-1:0] FIFO_DATA,
  output logic                  LANE_BUSY,
  output logic                  DROP
);

  localparam int IW = idx_w(SAMPLES_PER_WORD);
  localparam logic [IW-1:0] LAST = IW'(SAMPLES_PER_WORD - 1);

  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] pack_q;
  logic [DATA_WIDTH-1:0] word;
  logic                  issue;

  // Merge the incoming sample into its lane of the pending word.
  always_comb begin
    word = pack_q;
    for (int l = 0; l < SAMPLES_PER_WORD; l++) begin
      if (STROBE && idx_q == IW'(l)) begin
        word[l*ADC_WIDTH +: ADC_WIDTH] = SAMPLE;
      end
    end
  end

  assign issue     = (STROBE && idx_q == LAST) || FLUSH;
  assign DROP      = issue && FIFO_FULL;
  assign LANE_BUSY = (idx_q != '0);

  // Lane index, pack register and registered FIFO write port.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx_q     <= '0;
      pack_q    <= '0;
      FIFO_WR   <= 1'b0;
      FIFO_DATA <= '0;
    end else begin
      FIFO_WR <= issue && !FIFO_FULL;
      if (issue && !FIFO_FULL) begin
        FIFO_DATA <= word;
      end
      if (CLR || issue) begin
        idx_q  <= '0;
        pack_q <= '0;
      end else if (STROBE) begin
        idx_q  <= idx_q + 1'b1;
        pack_q <= word;
      end
    end
  end

endmodule

// File: rtl/nmr_acq_capture.sv
// NMR acquisition capture: samples ADC data inside acquisition windows,
// packs it to the FIFO and keeps per-scan echo/sample counts and overflow.
module nmr_acq_capture
  import nmr_pkg::*;
#(
  parameter int ADC_WIDTH        = ADC_W_DEF,
  parameter int SAMPLES_PER_WORD = 2,
  parameter int DATA_WIDTH       = DATA_W_DEF,
  parameter int SAMPLE_CNT_WIDTH = 32,
  parameter int ECHO_CNT_WIDTH   = 16
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        FSMSTAT,
  input  logic                        ACQ_WND,
  input  logic                        ADC_CLK,
  input  logic [ADC_WIDTH-1:0]        ADC_DATA,
  input  logic                        CLR_STAT,
  input  logic                        FIFO_FULL,
  output logic                        FIFO_WR,
  output logic [DATA_WIDTH-1:0]       FIFO_DATA,
  output logic [SAMPLE_CNT_WIDTH-1:0] SAMPLE_CNT,
  output logic [ECHO_CNT_WIDTH-1:0]   ECHO_CNT,
  output logic                        OVERFLOW,
  output logic                        CAPTURING
);

  state_t state_q;
  state_t state_d;
  logic   adc_clk_d;
  logic   strobe;
  logic   scan_start;
  logic   echo_inc;
  logic   flush;
  logic   lane_busy;
  logic   drop;

  // Delay ADC_CLK one cycle for rising-edge detection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) adc_clk_d <= 1'b0;
    else       adc_clk_d <= ADC_CLK;
  end

  assign strobe = ADC_CLK && !adc_clk_d && ACQ_WND && (state_q == S_CAP);

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    scan_start = 1'b0;
    echo_inc   = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (FSMSTAT) begin
          scan_start = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ACQ_WND) begin
          echo_inc = 1'b1;
          state_d  = S_CAP;
        end else if (!FSMSTAT) begin
          state_d = S_IDLE;
        end
      end
      S_CAP: begin
        if (!ACQ_WND) begin
          state_d = lane_busy ? S_FLUSH : S_WAIT;
        end
      end
      S_FLUSH: begin
        flush   = 1'b1;
        state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-scan counters and sticky overflow; a new drop beats CLR_STAT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SAMPLE_CNT <= '0;
      ECHO_CNT   <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      if (scan_start) begin
        SAMPLE_CNT <= '0;
        ECHO_CNT   <= '0;
      end else begin
        if (strobe && SAMPLE_CNT != '1) SAMPLE_CNT <= SAMPLE_CNT + 1'b1;
        if (echo_inc)                   ECHO_CNT   <= ECHO_CNT + 1'b1;
      end
      if (drop)                         OVERFLOW <= 1'b1;
      else if (CLR_STAT || scan_start)  OVERFLOW <= 1'b0;
    end
  end

  assign CAPTURING = (state_q == S_CAP) || (state_q == S_FLUSH);

  nmr_sample_packer #(
    .ADC_WIDTH        (ADC_WIDTH),
    .SAMPLES_PER_WORD (SAMPLES_PER_WORD),
    .DATA_WIDTH       (DATA_WIDTH)
  ) u_packer (
    .CLK       (CLK),
    .RESET     (RESET),
    .CLR       (scan_start),
    .STROBE    (strobe),
    .SAMPLE    (ADC_DATA),
    .FLUSH     (flush),
    .FIFO_FULL (FIFO_FULL),
    .FIFO_WR   (FIFO_WR),
    .FIFO_DATA (FIFO_DATA),
    .LANE_BUSY (lane_busy),
    .DROP      (drop)
  );

endmodule

// File: tb/tb_nmr_acq_capture.sv
// Bench for nmr_acq_capture: table of acquisition windows with a word
// scoreboard, plus hand sequences for overflow, scan restart and reset.
module tb_nmr_acq_capture;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FSMSTAT;
  logic        ACQ_WND;
  logic        ADC_CLK;
  logic [15:0] ADC_DATA;
  logic        CLR_STAT;
  logic        FIFO_FULL;
  logic        FIFO_WR;
  logic [31:0] FIFO_DATA;
  logic [31:0] SAMPLE_CNT;
  logic [15:0] ECHO_CNT;
  logic        OVERFLOW;
  logic        CAPTURING;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [3:0]       n;
    logic [7:0][15:0] d;
    logic [3:0]       blk;
    logic             cs;
    logic [31:0]      sc;
    logic [15:0]      ec;
    logic             ovf;
  } vec_t;

  vec_t tbl[4];

  nmr_acq_capture dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FSMSTAT    (FSMSTAT),
    .ACQ_WND    (ACQ_WND),
    .ADC_CLK    (ADC_CLK),
    .ADC_DATA   (ADC_DATA),
    .CLR_STAT   (CLR_STAT),
    .FIFO_FULL  (FIFO_FULL),
    .FIFO_WR    (FIFO_WR),
    .FIFO_DATA  (FIFO_DATA),
    .SAMPLE_CNT (SAMPLE_CNT),
    .ECHO_CNT   (ECHO_CNT),
    .OVERFLOW   (OVERFLOW),
    .CAPTURING  (CAPTURING)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every write must match the oldest expected word.
  always @(negedge CLK) begin
    if (FIFO_WR) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fifo_word got=%h required=no_write", FIFO_DATA);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (FIFO_DATA !== e) begin
          errors++;
          $display("FAIL fifo_word got=%h required=%h", FIFO_DATA, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic adc_edge(input logic [15:0] d, input logic ff,
                          input logic cs);
    ADC_CLK   = 1'b1;
    ADC_DATA  = d;
    FIFO_FULL = ff;
    CLR_STAT  = cs;
    cyc(1);
    ADC_CLK   = 1'b0;
    FIFO_FULL = 1'b0;
    CLR_STAT  = 1'b0;
    cyc(3);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr"}, FIFO_WR, 0);
    chk({tag, "_data"}, FIFO_DATA, 0);
    chk({tag, "_scnt"}, SAMPLE_CNT, 0);
    chk({tag, "_ecnt"}, ECHO_CNT, 0);
    chk({tag, "_ovf"}, OVERFLOW, 0);
    chk({tag, "_cap"}, CAPTURING, 0);
  endtask

  // One acquisition window; blk selects a full word hit by FIFO_FULL.
  task automatic run_win(input vec_t v, input string tag);
    int w0;
    w0 = wr_cnt;
    ACQ_WND = 1'b1;
    cyc(1);
    for (int i = 0; i < int'(v.n); i++) begin
      logic full_w;
      logic ff;
      full_w = (i % 2 == 1);
      ff     = full_w && ((i / 2) == int'(v.blk));
      if (full_w && !ff) exp_q.push_back({v.d[i], v.d[i-1]});
      adc_edge(v.d[i], ff, v.cs && ff);
    end
    if (v.n[0]) exp_q.push_back({16'h0000, v.d[v.n-1]});
    ACQ_WND = 1'b0;
    cyc(4);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_scnt"}, SAMPLE_CNT, v.sc);
    chk({tag, "_ecnt"}, ECHO_CNT, v.ec);
    chk({tag, "_ovf"}, OVERFLOW, v.ovf);
    if (tag == "ovf") chk("ovf_writes", wr_cnt - w0, 3);
  endtask

  initial begin
    vec_t v;
    int   w0;

    tbl[0] = '{n: 8, d: {16'h8, 16'h7, 16'h6, 16'h5,
                         16'h4, 16'h3, 16'h2, 16'h1},
               blk: 4'hF, cs: 0, sc: 8, ec: 1, ovf: 0};
    tbl[1] = '{n: 3, d: {80'h0, 16'hCCCC, 16'hBBBB, 16'hAAAA},
               blk: 4'hF, cs: 0, sc: 11, ec: 2, ovf: 0};
    tbl[2] = '{n: 8, d: {16'h17, 16'h16, 16'h15, 16'h14,
                         16'h13, 16'h12, 16'h11, 16'h10},
               blk: 4'h1, cs: 0, sc: 19, ec: 3, ovf: 1};
    tbl[3] = '{n: 2, d: {96'h0, 16'hBEEF, 16'hDEAD},
               blk: 4'h0, cs: 1, sc: 2, ec: 1, ovf: 1};

    RESET = 1'b1; FSMSTAT = 1'b0; ACQ_WND = 1'b0; ADC_CLK = 1'b0;
    ADC_DATA = '0; CLR_STAT = 1'b0; FIFO_FULL = 1'b0;
    cyc(3);
    chk_zero("reset");
    RESET = 1'b0;
    cyc(2);

    // Scan 1
    FSMSTAT = 1'b1;
    cyc(2);
    run_win(tbl[0], "win8");
    run_win(tbl[1], "win3");
    run_win(tbl[2], "ovf");
    cyc(5);
    chk("ovf_held", OVERFLOW, 1);

    // ADC edges outside a window are ignored
    w0 = wr_cnt;
    adc_edge(16'h5555, 0, 0);
    adc_edge(16'h6666, 0, 0);
    chk("nownd_writes", wr_cnt - w0, 0);
    chk("nownd_scnt", SAMPLE_CNT, 19);

    for (int k = 0; k < 7; k++) begin
      v     = '0;
      v.n   = 2;
      v.d[0] = 16'($urandom);
      v.d[1] = 16'($urandom);
      v.blk = 4'hF;
      v.sc  = 32'(21 + 2 * k);
      v.ec  = 16'(4 + k);
      v.ovf = 1'b1;
      run_win(v, "scan1");
    end

    // End of scan: counts held, window with FSMSTAT low ignored
    FSMSTAT = 1'b0;
    cyc(3);
    chk("held_ecnt", ECHO_CNT, 10);
    chk("held_scnt", SAMPLE_CNT, 33);
    w0 = wr_cnt;
    ACQ_WND = 1'b1;
    cyc(1);
    adc_edge(16'h7777, 0, 0);
    adc_edge(16'h8888, 0, 0);
    ACQ_WND = 1'b0;
    cyc(3);
    chk("idle_writes", wr_cnt - w0, 0);
    chk("idle_ecnt", ECHO_CNT, 10);
    chk("idle_scnt", SAMPLE_CNT, 33);
    chk("idle_cap", CAPTURING, 0);

    // Scan 2: counters and overflow cleared on start
    FSMSTAT = 1'b1;
    cyc(2);
    chk("scan2_ecnt", ECHO_CNT, 0);
    chk("scan2_scnt", SAMPLE_CNT, 0);
    chk("scan2_ovf", OVERFLOW, 0);
    run_win(tbl[3], "ovf_vs_clr");
    CLR_STAT = 1'b1;
    cyc(1);
    CLR_STAT = 1'b0;
    cyc(1);
    chk("clr_stat", OVERFLOW, 0);
    for (int k = 0; k < 9; k++) begin
      v     = '0;
      v.n   = 2;
      v.d[0] = 16'($urandom);
      v.d[1] = 16'($urandom);
      v.blk = 4'hF;
      v.sc  = 32'(4 + 2 * k);
      v.ec  = 16'(2 + k);
      v.ovf = 1'b0;
      run_win(v, "scan2");
    end
    chk("scan2_ecnt10", ECHO_CNT, 10);

    // Reset with lane 0 filled mid-window
    w0 = wr_cnt;
    ACQ_WND = 1'b1;
    cyc(1);
    ADC_CLK = 1'b1;
    ADC_DATA = 16'h9999;
    cyc(1);
    ADC_CLK = 1'b0;
    cyc(1);
    chk("mid_scnt", SAMPLE_CNT, 21);
    RESET = 1'b1;
    ACQ_WND = 1'b0;
    cyc(1);
    chk_zero("midrst");
    chk("midrst_writes", wr_cnt - w0, 0);
    RESET = 1'b0;
    cyc(2);
    v     = '0;
    v.n   = 2;
    v.d[0] = 16'h1234;
    v.d[1] = 16'h5678;
    v.blk = 4'hF;
    v.sc  = 2;
    v.ec  = 1;
    v.ovf = 0;
    run_win(v, "postrst");
    chk("postrst_data", FIFO_DATA, 32'h56781234);

    cyc(4);
    chk("final_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
